// File: rtl/memlcd_pkg.sv
// Shared memory-LCD panel geometry and capture-side state encoding.
// Used by both the panel driver and memlcd_capture so frame geometry always agrees.
package memlcd_pkg;

    localparam int LCD_DATA_WIDTH      = 6;
    localparam int LCD_WORDS_PER_LINE  = 120;
    localparam int LCD_LINES_PER_FRAME = 640;
    // BCK edges at the start of each line that carry no pixel data.
    localparam int LCD_DUMMY_EDGES     = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BSP = 2'd1,
        SKIP     = 2'd2,
        CAPTURE  = 2'd3
    } capture_state_t;

endpackage

// File: rtl/memlcd_edge_sync.sv
// Per-signal input stage: optional 2-flop synchronizer (MEMLCD_CAPTURE_SYNC_EN),
// then an edge-detect register and a previous-value register.
module memlcd_edge_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_any_edge
);

    logic w_front;
    logic r_det;
    logic r_prev;

`ifdef MEMLCD_CAPTURE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[0], i_d};
    end

    assign w_front = r_sync[1];
`else
    logic r_in;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_in <= 1'b0;
        else         r_in <= i_d;
    end

    assign w_front = r_in;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_det  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_det  <= w_front;
            r_prev <= r_det;
        end
    end

    assign o_level    = r_det;
    assign o_rise     = r_det & ~r_prev;
    assign o_any_edge = r_det ^ r_prev;

endmodule

// File: rtl/memlcd_capture.sv
// Memory-LCD bus receiver: decodes GSP/BSP/BCK/RGB back into a word stream with
// line/word coordinates. MEMLCD_CAPTURE_SYNC_EN adds input synchronizers.
module memlcd_capture
    import memlcd_pkg::*;
#(
    parameter  int DATA_WIDTH      = LCD_DATA_WIDTH,
    parameter  int WORDS_PER_LINE  = LCD_WORDS_PER_LINE,
    parameter  int LINES_PER_FRAME = LCD_LINES_PER_FRAME,
    localparam int LINE_W          = $clog2(LINES_PER_FRAME),
    localparam int WORD_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_gsp,
    input  logic                  i_bsp,
    input  logic                  i_bck,
    input  logic [DATA_WIDTH-1:0] i_rgb,
    input  logic                  i_wfull,
    input  logic                  i_err_clr,
    output logic                  o_winc,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [LINE_W-1:0]     o_line,
    output logic [WORD_W-1:0]     o_word,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_frame_done,
    output logic                  o_err_ovf,
    output logic                  o_err_len,
    output capture_state_t        o_dbg_state
);

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

`ifdef MEMLCD_CAPTURE_SYNC_EN
    localparam int RGB_STAGES = 3;
`else
    localparam int RGB_STAGES = 2;
`endif

    logic w_gsp_level, w_gsp_rise, w_gsp_edge;
    logic w_bsp_level, w_bsp_rise, w_bsp_edge;
    logic w_bck_level, w_bck_rise, w_bck_edge;
    logic w_unused;

    memlcd_edge_sync u_sync_gsp (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_gsp),
        .o_level(w_gsp_level), .o_rise(w_gsp_rise), .o_any_edge(w_gsp_edge)
    );

    memlcd_edge_sync u_sync_bsp (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_bsp),
        .o_level(w_bsp_level), .o_rise(w_bsp_rise), .o_any_edge(w_bsp_edge)
    );

    memlcd_edge_sync u_sync_bck (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_bck),
        .o_level(w_bck_level), .o_rise(w_bck_rise), .o_any_edge(w_bck_edge)
    );

    assign w_unused = ^{w_gsp_level, w_gsp_edge, w_bsp_level, w_bsp_edge, w_bck_level, w_bck_rise};

    // RGB delay matches the edge-detect depth so the last stage lines up with the BCK edge.
    logic [DATA_WIDTH-1:0] r_rgb_pipe [RGB_STAGES];
    logic [DATA_WIDTH-1:0] w_rgb;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < RGB_STAGES; i++) r_rgb_pipe[i] <= '0;
        end else begin
            r_rgb_pipe[0] <= i_rgb;
            for (int i = 1; i < RGB_STAGES; i++) r_rgb_pipe[i] <= r_rgb_pipe[i-1];
        end
    end

    assign w_rgb = r_rgb_pipe[RGB_STAGES-1];

    capture_state_t    r_state;
    logic [LINE_W-1:0] r_line;
    logic [WORD_W-1:0] r_word;
    logic              r_done_pend;
    logic [LINE_W-1:0] w_line_next;

    assign w_line_next = (r_line == LAST_LINE) ? r_line : r_line + 1'b1;
    assign o_dbg_state = r_state;

    // Error sets are written after the clear so a same-cycle error keeps its flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_line       <= '0;
            r_word       <= '0;
            r_done_pend  <= 1'b0;
            o_winc       <= 1'b0;
            o_wdata      <= '0;
            o_line       <= '0;
            o_word       <= '0;
            o_sof        <= 1'b0;
            o_eol        <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_ovf    <= 1'b0;
            o_err_len    <= 1'b0;
        end else begin
            o_winc       <= 1'b0;
            o_sof        <= 1'b0;
            o_eol        <= 1'b0;
            o_frame_done <= r_done_pend;
            r_done_pend  <= 1'b0;
            if (i_err_clr) begin
                o_err_ovf <= 1'b0;
                o_err_len <= 1'b0;
            end

            if (w_gsp_rise) begin
                if (!((r_state == IDLE) || (r_state == WAIT_BSP && r_line == '0)))
                    o_err_len <= 1'b1;
                r_line  <= '0;
                r_state <= w_bsp_rise ? SKIP : WAIT_BSP;
            end else begin
                case (r_state)
                    IDLE: begin
                    end
                    WAIT_BSP: begin
                        if (w_bsp_rise) r_state <= SKIP;
                    end
                    SKIP, CAPTURE: begin
                        if (w_bsp_rise) begin
                            o_err_len <= 1'b1;
                            r_line    <= w_line_next;
                            r_state   <= SKIP;
                        end else if (w_bck_edge) begin
                            if (r_state == SKIP) begin
                                r_word  <= '0;
                                r_state <= CAPTURE;
                            end else begin
                                o_wdata <= w_rgb;
                                o_line  <= r_line;
                                o_word  <= r_word;
                                o_sof   <= !i_wfull && (r_line == '0) && (r_word == '0);
                                o_eol   <= !i_wfull && (r_word == LAST_WORD);
                                if (i_wfull) o_err_ovf <= 1'b1;
                                else         o_winc    <= 1'b1;
                                if (r_word == LAST_WORD) begin
                                    r_line <= w_line_next;
                                    if (r_line == LAST_LINE) begin
                                        r_done_pend <= 1'b1;
                                        r_state     <= IDLE;
                                    end else begin
                                        r_state <= WAIT_BSP;
                                    end
                                end else begin
                                    r_word <= r_word + 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
